// File: rtl/ga_mutation_mc_pkg.sv
// Shared GA definitions: FSM states, mutation-mode encodings and default
// width constants derived from the default weight/chromosome geometry.
package ga_mutation_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_MUTATE = 2'd2,
        ST_PUSH   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_BYPASS    = 2'd0,
        MODE_FIXED     = 2'd1,
        MODE_ADAPTIVE  = 2'd2,
        MODE_FIXED_ALT = 2'd3
    } mode_t;

    localparam int GA_DATA_INT_W   = 1;
    localparam int GA_DATA_FRACT_W = 5;
    localparam int GA_DATA_W       = GA_DATA_INT_W + GA_DATA_FRACT_W;
    localparam int GA_M_MAX        = 32;
    localparam int GA_M_MAX_W      = $clog2(GA_M_MAX + 1);
    localparam int GA_M_IDX_MAX_W  = $clog2(GA_M_MAX);
    localparam int GA_FIT_SCORE_W  = 18;
    localparam int GA_K_MAX        = 4;
    localparam int GA_K_W          = $clog2(GA_K_MAX + 1);
    localparam int GA_RAND_W       = GA_M_IDX_MAX_W + GA_DATA_W;

endpackage

// File: rtl/ga_sat_add.sv
// Signed two's-complement adder that clamps to the DATA_W range on overflow.
module ga_sat_add #(
    parameter int DATA_W = 6
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] sum
);

    logic signed [DATA_W:0] full;

    always_comb begin
        full = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
        sum  = full[DATA_W-1:0];
        // Overflow shows up as disagreement between the two top bits.
        if (full[DATA_W] != full[DATA_W-1]) begin
            sum = full[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                               : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/ga_mutation_mc.sv
// GA mutation stage: takes one child chromosome, applies k random weight
// mutations (k fixed or fitness-adaptive), then pushes it to the queue.
module ga_mutation_mc
    import ga_mutation_mc_pkg::*;
#(
    parameter  int DATA_INT_W   = GA_DATA_INT_W,
    parameter  int DATA_FRACT_W = GA_DATA_FRACT_W,
    parameter  int M_MAX        = GA_M_MAX,
    parameter  int FIT_SCORE_W  = GA_FIT_SCORE_W,
    parameter  int K_MAX        = GA_K_MAX,
    localparam int DATA_W       = DATA_INT_W + DATA_FRACT_W,
    localparam int M_MAX_W      = $clog2(M_MAX + 1),
    localparam int M_IDX_MAX_W  = $clog2(M_MAX),
    localparam int K_W          = $clog2(K_MAX + 1),
    localparam int RAND_W       = M_IDX_MAX_W + DATA_W
) (
    input  logic                     clk,
    input  logic                     sw_rst,
    input  logic [M_MAX_W-1:0]       cnfg_m,
    input  logic [FIT_SCORE_W-1:0]   cnfg_max_fit_score,
    input  logic [1:0]               cnfg_mode,
    input  logic                     cnfg_op,
    input  logic [K_W-1:0]           cnfg_k,
    input  logic [RAND_W-1:0]        rand_data,
    input  logic [FIT_SCORE_W-1:0]   gen_best_score,
    input  logic                     child_valid,
    input  logic [DATA_W*M_MAX-1:0]  child,
    output logic                     child_ack,
    input  logic                     queue_full,
    output logic                     queue_push,
    output logic [DATA_W*M_MAX-1:0]  queue_chromosome,
    output logic [15:0]              stat_mut_cnt
);

    localparam logic [K_W-1:0] K_LIMIT = K_W'(K_MAX);

    state_t                    state;
    logic [DATA_W*M_MAX-1:0]   work;
    logic [M_MAX_W-1:0]        m_r;
    logic                      op_r;
    logic [K_W-1:0]            k_cnt;

    logic [K_W-1:0]            k_lim;
    logic [K_W-1:0]            k_half;
    logic [K_W-1:0]            k_calc;
    mode_t                     mode_v;
    logic [M_IDX_MAX_W-1:0]    r_idx;
    logic [DATA_W-1:0]         r_val;
    logic                      hit;
    logic signed [DATA_W-1:0]  cur_w;
    logic signed [DATA_W-1:0]  sat_w;

    always_comb begin
        k_lim  = (cnfg_k > K_LIMIT) ? K_LIMIT : cnfg_k;
        k_half = k_lim >> 1;
        mode_v = mode_t'(cnfg_mode);
        k_calc = k_lim;
        case (mode_v)
            MODE_BYPASS: k_calc = '0;
            MODE_ADAPTIVE: begin
                if (gen_best_score < (cnfg_max_fit_score >> 2))
                    k_calc = k_lim;
                else if (gen_best_score < (cnfg_max_fit_score >> 1))
                    k_calc = (k_half == '0) ? K_W'(1) : k_half;
                else
                    k_calc = (k_lim == '0) ? '0 : K_W'(1);
            end
            default: k_calc = k_lim;
        endcase
    end

    always_comb begin
        r_idx = rand_data[RAND_W-1 -: M_IDX_MAX_W];
        r_val = rand_data[DATA_W-1:0];
        hit   = M_MAX_W'(r_idx) < m_r;
        cur_w = work[int'(r_idx)*DATA_W +: DATA_W];
    end

    ga_sat_add #(
        .DATA_W(DATA_W)
    ) u_sat_add (
        .a  (cur_w),
        .b  (r_val),
        .sum(sat_w)
    );

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            state        <= ST_IDLE;
            child_ack    <= 1'b0;
            work         <= '0;
            m_r          <= '0;
            op_r         <= 1'b0;
            k_cnt        <= '0;
            stat_mut_cnt <= '0;
        end else begin
            child_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (child_valid) begin
                        work      <= child;
                        child_ack <= 1'b1;
                        state     <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    m_r   <= cnfg_m;
                    op_r  <= cnfg_op;
                    k_cnt <= k_calc;
                    state <= (k_calc == '0) ? ST_PUSH : ST_MUTATE;
                end
                ST_MUTATE: begin
                    if (hit) begin
                        work[int'(r_idx)*DATA_W +: DATA_W] <= op_r ? sat_w : r_val;
                        if (stat_mut_cnt != 16'hFFFF)
                            stat_mut_cnt <= stat_mut_cnt + 16'd1;
                    end
                    k_cnt <= k_cnt - K_W'(1);
                    if (k_cnt == K_W'(1))
                        state <= ST_PUSH;
                end
                ST_PUSH: begin
                    if (!queue_full)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Push is combinational on queue_full so the handshake completes in-cycle.
    assign queue_push = (state == ST_PUSH) && !queue_full;

    always_comb begin
        queue_chromosome = '0;
        for (int unsigned i = 0; i < M_MAX; i++) begin
            if (i < 32'(m_r))
                queue_chromosome[i*DATA_W +: DATA_W] = work[i*DATA_W +: DATA_W];
        end
    end

endmodule

// File: doc/ga_mutation_mc.md
GA_MUTATION_MC -- requirements
Module: ga_mutation_mc

Interface
REQ-001 SHALL have parameter DATA_INT_W, default 1, integer bits of one signed weight.
REQ-002 SHALL have parameter DATA_FRACT_W, default 5, fraction bits; DATA_W = DATA_INT_W+DATA_FRACT_W.
REQ-003 SHALL have parameter M_MAX, default 32, max weights per chromosome; M_MAX_W = $clog2(M_MAX+1), M_IDX_MAX_W = $clog2(M_MAX).
REQ-004 SHALL have parameter FIT_SCORE_W, default 18, unsigned fitness-score width.
REQ-005 SHALL have parameter K_MAX, default 4, max mutations per child; K_W = $clog2(K_MAX+1); RAND_W = M_IDX_MAX_W+DATA_W.
REQ-006 SHALL have ports: clk in 1, sole clock; sw_rst in 1, synchronous active-high reset.
REQ-007 SHALL have ports: cnfg_m in M_MAX_W, active weights (1..M_MAX); cnfg_max_fit_score in FIT_SCORE_W; cnfg_mode in 2, 0 bypass/1 fixed/2 adaptive/3 treated as fixed; cnfg_op in 1, 0 replace/1 saturating add; cnfg_k in K_W, mutations per child (values above K_MAX clamp to K_MAX).
REQ-008 SHALL have ports: rand_data in RAND_W, fresh every cycle, {idx[M_IDX_MAX_W-1:0], val[DATA_W-1:0]}; gen_best_score in FIT_SCORE_W.
REQ-009 SHALL have ports: child_valid in 1; child in DATA_W*M_MAX, weight i at [i*DATA_W +: DATA_W]; child_ack out 1.
REQ-010 SHALL have ports: queue_full in 1; queue_push out 1; queue_chromosome out DATA_W*M_MAX; stat_mut_cnt out 16, applied-mutation count.

Function
REQ-011 SHALL implement FSM IDLE->CALC->MUTATE->PUSH->IDLE; CALC->PUSH directly when k=0.
REQ-012 In IDLE with child_valid=1 at clk edge, SHALL register child and assert child_ack for exactly the next cycle; child_ack SHALL be 0 in every other state.
REQ-013 In CALC (one cycle) SHALL sample cnfg_* and gen_best_score and compute k: bypass k=0; fixed k=min(cnfg_k,K_MAX); adaptive: score<max/4 -> k=min(cnfg_k,K_MAX); max/4<=score<max/2 -> k=max(1,floor(min(cnfg_k,K_MAX)/2)); score>=max/2 -> k=1 (k=0 if cnfg_k=0); max/4, max/2 via right shift.
REQ-014 MUTATE SHALL last exactly k cycles, one rand_data sample per cycle.
REQ-015 Per MUTATE cycle: idx>=cnfg_m -> no change, not counted; else weight[idx] = val (op 0) or signed weight[idx]+val saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1] (op 1).
REQ-016 PUSH: queue_push = ~queue_full combinationally; leave PUSH on the edge where queue_push=1; stay in PUSH while queue_full=1 with queue_chromosome stable.
REQ-017 queue_chromosome SHALL be the working register with weights i>=cnfg_m forced to zero.
REQ-018 Latency without backpressure: queue_push high in cycle k+2 counting the cycle after capture edge as cycle 1; throughput one child per k+3 cycles.
REQ-019 stat_mut_cnt SHALL increment per applied mutation, saturating at 16'hFFFF.
REQ-020 Changes to cnfg_*/gen_best_score outside CALC SHALL not affect the in-flight child.

Reset
REQ-021 sw_rst=1 at clk edge SHALL force IDLE, child_ack=0, queue_push=0, queue_chromosome=0, stat_mut_cnt=0, k counter=0, from any state.
REQ-022 A child in flight during reset SHALL be discarded, never pushed.

Structure
REQ-023 The shared GA package SHALL hold the FSM state enum, cnfg_mode encodings and the DATA_W/M_MAX/K_MAX-derived width constants.
REQ-024 SHALL contain one sub-module ga_sat_add (signed DATA_W saturating adder); the rest stays flat.

Verification
REQ-025 cnfg_m=7, mode=1, op=0, k=2, child {7,6,5,4,3,2,1}, rand idx=2 val=6'h1F then idx=20 -> weight2=0x1F, others unchanged, push in cycle 4, stat_mut_cnt=1.
REQ-026 mode=2, max=32<<10, op=0, cnfg_k=4, scores 1, 200<<10... -> score 1 gives 4 MUTATE cycles; score 10<<10 gives 2; score>=16<<10 gives 1.
REQ-027 op=1, weight0=6'h1F, val=6'h05, idx=0 -> weight0=6'h1F (saturated); weight0=6'h20, val=6'h3F -> 6'h20.
REQ-028 mode=0, child_valid held, queue_full high 5 cycles in PUSH -> queue_push 0 for 5 cycles, then 1 for one cycle, chromosome stable, exactly one push per ack.
REQ-029 sw_rst asserted in MUTATE -> next cycle all outputs 0, no push for that child; next child processed normally.
REQ-030 21 back-to-back children, queue_full=0, k=1 -> exactly 21 acks, 21 pushes, one per 4 cycles.
